// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480@60 raster timing generator with registered, mutually aligned outputs.
// Optional frames-since-reset counter on frame_cnt when VGA_FRAME_CNT_EN is defined.
`timescale 1ns/1ps
module vga_sync_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic       clk_d,
   input  logic       reset_n,
   input  logic       en,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
   output logic       line_start,
   output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [7:0] frame_cnt
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [9:0] h_cnt_q, h_cnt_d;
   logic [9:0] v_cnt_q, v_cnt_d;
   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic       video_on_q, video_on_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       line_start_q, line_start_d;
   logic       frame_start_q, frame_start_d;

   // Outputs describe the pixel the counters held before this enabled edge.
   always_comb begin
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      x_d           = x_q;
      y_d           = y_q;
      video_on_d    = video_on_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (en) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = 10'd0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
         end else begin
            h_cnt_d = h_cnt_q + 10'd1;
         end
         x_d           = h_cnt_q;
         y_d           = v_cnt_q;
         video_on_d    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
         hsync_d       = (h_cnt_q >= HS_FIRST && h_cnt_q <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
         vsync_d       = (v_cnt_q >= VS_FIRST && v_cnt_q <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
         line_start_d  = (h_cnt_q == 10'd0);
         frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
      end
   end

   always_ff @(posedge clk_d or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt_q       <= 10'd0;
         v_cnt_q       <= 10'd0;
         x_q           <= 10'd0;
         y_q           <= 10'd0;
         video_on_q    <= 1'b0;
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         x_q           <= x_d;
         y_q           <= y_d;
         video_on_q    <= video_on_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign x           = x_q;
   assign y           = y_q;
   assign video_on    = video_on_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic       started_q, started_d;

   // The first frame after reset is frame 0, so the count only moves from the second one on.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      started_d   = started_q;
      if (en && h_cnt_q == 10'd0 && v_cnt_q == 10'd0) begin
         if (started_q) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
         end
         started_d = 1'b1;
      end
   end

   always_ff @(posedge clk_d or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt_q <= 8'd0;
         started_q   <= 1'b0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         started_q   <= started_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench for vga_sync_gen: full-size raster plus a tiny-timing instance.
`timescale 1ns/1ps
module tb_vga_sync_gen;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       vo;
      logic       hs;
      logic       vs;
      logic       ls;
      logic       fs;
      logic [7:0] fc;
   } out_t;

   typedef struct packed {
      out_t b;
      out_t s;
   } exp_t;

`ifdef VGA_FRAME_CNT_EN
   localparam bit HAS_FC = 1'b1;
`else
   localparam bit HAS_FC = 1'b0;
`endif

   logic       clk_d = 1'b0;
   logic       reset_n = 1'b0;
   logic       en = 1'b1;
   logic [9:0] b_x, b_y, s_x, s_y;
   logic       b_vo, b_hs, b_vs, b_ls, b_fs;
   logic       s_vo, s_hs, s_vs, s_ls, s_fs;
   logic [7:0] b_fc, s_fc;

   always #20 clk_d = ~clk_d;

   vga_sync_gen u_big (
      .clk_d(clk_d), .reset_n(reset_n), .en(en),
      .x(b_x), .y(b_y), .video_on(b_vo), .hsync(b_hs), .vsync(b_vs),
      .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_FRAME_CNT_EN
      , .frame_cnt(b_fc)
`endif
   );

   vga_sync_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) u_small (
      .clk_d(clk_d), .reset_n(reset_n), .en(en),
      .x(s_x), .y(s_y), .video_on(s_vo), .hsync(s_hs), .vsync(s_vs),
      .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_FRAME_CNT_EN
      , .frame_cnt(s_fc)
`endif
   );

`ifndef VGA_FRAME_CNT_EN
   assign b_fc = 8'd0;
   assign s_fc = 8'd0;
`endif

   int n_vec = 0;
   int n_bad = 0;

   function automatic void check(string name, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   function automatic void check_out(string name, out_t a, out_t e);
      n_vec++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got x=%0d y=%0d vo=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d expected x=%0d y=%0d vo=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d",
                  name, a.x, a.y, a.vo, a.hs, a.vs, a.ls, a.fs, a.fc,
                  e.x, e.y, e.vo, e.hs, e.vs, e.ls, e.fs, e.fc);
      end
   endfunction

   function automatic out_t rst_rec();
      out_t r;
      r.x = 10'd0; r.y = 10'd0; r.vo = 1'b0; r.hs = 1'b1; r.vs = 1'b1;
      r.ls = 1'b0; r.fs = 1'b0; r.fc = 8'd0;
      return r;
   endfunction

   // Reference raster: a linear pixel index split into x/y, decoded from the timing numbers.
   task automatic model_step(input int ha, hf, hw, hb, va, vf, vw, vb, input bit e,
                             inout int p, inout bit seen, inout out_t o);
      int ht, vt, xi, yi;
      ht = ha + hf + hw + hb;
      vt = va + vf + vw + vb;
      if (e) begin
         xi   = p % ht;
         yi   = p / ht;
         o.x  = 10'(xi);
         o.y  = 10'(yi);
         o.vo = (xi < ha) && (yi < va);
         o.hs = !(xi >= ha + hf && xi < ha + hf + hw);
         o.vs = !(yi >= va + vf && yi < va + vf + vw);
         o.ls = (xi == 0);
         o.fs = (p == 0);
         if (p == 0) begin
            if (HAS_FC && seen) o.fc = o.fc + 8'd1;
            seen = 1'b1;
         end
         p = (p + 1) % (ht * vt);
      end else begin
         o.ls = 1'b0;
         o.fs = 1'b0;
      end
   endtask

   exp_t q[$];
   int   pb = 0, ps = 0;
   bit   seenb = 1'b0, seens = 1'b0;
   out_t ob, os;

   task automatic cyc(input bit e, input bit r);
      @(negedge clk_d);
      reset_n = r;
      en      = e;
      if (!r) begin
         pb = 0; ps = 0; seenb = 1'b0; seens = 1'b0;
         ob = rst_rec(); os = rst_rec();
      end else begin
         model_step(640, 16, 96, 48, 480, 10, 2, 33, e, pb, seenb, ob);
         model_step(4, 1, 1, 1, 2, 1, 1, 1, e, ps, seens, os);
      end
      q.push_back('{b: ob, s: os});
   endtask

   task automatic settle();
      @(posedge clk_d);
      #2;
   endtask

   int   cyc_cnt = 0, vo_cnt = 0, hs_low_cnt = 0, hs_first_x = -1;
   int   last_ls = 0, ls_period = 0, ls_cnt = 0;
   int   vs_low_cnt = 0, last_fs = 0, fs_period = 0, fs_cnt_s = 0;
   int   fc_at2 = -1, fc_at257 = -1;
   exp_t cur;

   initial begin
      forever begin
         @(posedge clk_d);
         #1;
         if (q.size() > 0) begin
            cur = q.pop_front();
            check_out("big", '{b_x, b_y, b_vo, b_hs, b_vs, b_ls, b_fs, b_fc}, cur.b);
            check_out("small", '{s_x, s_y, s_vo, s_hs, s_vs, s_ls, s_fs, s_fc}, cur.s);
            cyc_cnt++;
            if (b_vo) vo_cnt++;
            if (!b_hs) begin
               if (hs_low_cnt == 0) hs_first_x = int'(b_x);
               hs_low_cnt++;
            end
            if (b_ls) begin
               ls_period = cyc_cnt - last_ls;
               last_ls   = cyc_cnt;
               ls_cnt++;
            end
            if (!s_vs) vs_low_cnt++;
            if (s_fs) begin
               fs_period = cyc_cnt - last_fs;
               last_fs   = cyc_cnt;
               fs_cnt_s++;
               if (fs_cnt_s == 2)   fc_at2   = int'(s_fc);
               if (fs_cnt_s == 257) fc_at257 = int'(s_fc);
            end
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL timeout: simulation exceeded time bound");
      $fatal(1, "timeout");
   end

   initial begin
      ob = rst_rec();
      os = rst_rec();
      repeat (3) cyc(1'b1, 1'b0);
      settle();
      check("rst_x", b_x, 0);
      check("rst_video_on", b_vo, 0);
      check("rst_hsync", b_hs, 1);
      check("rst_vsync", b_vs, 1);

      cyc(1'b1, 1'b1);
      settle();
      check("first_x", b_x, 0);
      check("first_y", b_y, 0);
      check("first_video_on", b_vo, 1);
      check("first_frame_start", b_fs, 1);
      check("first_line_start", b_ls, 1);

      repeat (69) cyc(1'b1, 1'b1);
      settle();
      check("small_vsync_low_2frames", vs_low_cnt, 14);
      check("small_frame_period", fs_period, 35);
      check("small_frames_seen", fs_cnt_s, 2);

      repeat (730) cyc(1'b1, 1'b1);
      settle();
      check("line_video_on_cycles", vo_cnt, 640);
      check("line_hsync_low_cycles", hs_low_cnt, 96);
      check("line_hsync_first_x", hs_first_x, 656);
      cyc(1'b1, 1'b1);
      settle();
      check("line_start_period", ls_period, 800);
      check("line1_y", b_y, 1);

      for (int i = 0; i < 5000; i++) begin
         if (ob.x == 10'd100 && ob.y == 10'd5) break;
         cyc(1'b1, 1'b1);
      end
      repeat (10) cyc(1'b0, 1'b1);
      settle();
      check("stall_x", b_x, 100);
      check("stall_y", b_y, 5);
      check("stall_hsync", b_hs, 1);
      check("stall_line_start", b_ls, 0);
      cyc(1'b1, 1'b1);
      settle();
      check("resume_x", b_x, 101);

      for (int i = 0; i < 1000; i++) begin
         if (ob.x == 10'd799) break;
         cyc(1'b1, 1'b1);
      end
      settle();
      ls_cnt = 0;
      cyc(1'b1, 1'b1);
      repeat (10) cyc(1'b0, 1'b1);
      repeat (5) cyc(1'b1, 1'b1);
      settle();
      check("stall_at_x0_line_start_pulses", ls_cnt, 1);

      for (int i = 0; i < 1000; i++) begin
         if (ob.x == 10'd300) break;
         cyc(1'b1, 1'b1);
      end
      settle();
      check("pre_reset_x", b_x, 300);
      #3;
      reset_n = 1'b0;
      #1;
      check("async_rst_x", b_x, 0);
      check("async_rst_y", b_y, 0);
      check("async_rst_video_on", b_vo, 0);
      check("async_rst_hsync", b_hs, 1);
      check("async_rst_small_x", s_x, 0);
      fs_cnt_s = 0;
      ob = rst_rec(); os = rst_rec();
      pb = 0; ps = 0; seenb = 1'b0; seens = 1'b0;
      repeat (2) cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b1);
      settle();
      check("restart_x", b_x, 0);
      check("restart_y", b_y, 0);
      check("restart_frame_start", b_fs, 1);

      repeat (8960) cyc(1'b1, 1'b1);
      settle();
      check("small_frames_257", fs_cnt_s, 257);
`ifdef VGA_FRAME_CNT_EN
      check("frame_cnt_at_2nd", fc_at2, 1);
      check("frame_cnt_at_257th", fc_at257, 0);
      check("big_frame_cnt_frame0", b_fc, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
